// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-entry register file for the RISC core datapath. It has two
//   combinational read ports and one clocked write port. Write-to-read
//   bypass and a hardwired-zero r0 are both optional. A per-register
//   pending scoreboard lets decode detect RAW hazards against outstanding
//   multi-cycle writebacks such as loads.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   rs, rt     read addresses for port 1 and port 2
//   rd, rw, wr write address, write data and write enable
//   rout1/2    read data, combinational
//   pend_set   mark register pend_addr as pending
//   pend_addr  register to mark pending
//   hazard1/2  register rs / rt is pending and not resolved this cycle
//   pend_cnt   registered count of pending registers, 0 .. 2**ADDR_W

// One register plus its pending bit. The top level decodes the write
// enable and the pend_set strobe for this entry.
module reg_file_sb_entry #(
   parameter int DATA_W = 16,
   parameter bit ZERO   = 1'b0   // hardwired-zero entry
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pset,
   output logic [DATA_W-1:0] q,
   output logic              pend,
   output logic              pend_nxt
);
   logic [DATA_W-1:0] data_q;
   logic              pend_q;
   logic              we_eff;
   logic              pset_eff;

   // A hardwired-zero entry ignores writes and pend_set. Its flops never
   // change, so synthesis is free to remove them.
   assign we_eff   = we   & ~ZERO;
   assign pset_eff = pset & ~ZERO;

   // A set wins over a same-cycle clear: the new load was issued after the
   // writeback that is landing now.
   assign pend_nxt = rst ? 1'b0 : (pset_eff | (pend_q & ~we_eff));

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         pend_q <= 1'b0;
      end else begin
         if (we_eff) data_q <= wdata;
         pend_q <= pend_nxt;
      end
   end

   assign q    = ZERO ? '0 : data_q;
   assign pend = pend_q;
endmodule

module reg_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] rw,
   input  logic              wr,
   output logic [DATA_W-1:0] rout1,
   output logic [DATA_W-1:0] rout2,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              hazard1,
   output logic              hazard2,
   output logic [ADDR_W:0]   pend_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BYP   = (BYPASS != 0);

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             pend;
   logic [DEPTH-1:0]             pend_nxt;
   logic [DEPTH-1:0]             we_vec;
   logic [DEPTH-1:0]             ps_vec;
   logic [ADDR_W:0]              cnt_nxt;

   // Entries are only written while rst is low. During reset each entry
   // clears itself regardless of its strobes.
   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_ent
         assign we_vec[i] = wr       & (rd        == ADDR_W'(i));
         assign ps_vec[i] = pend_set & (pend_addr == ADDR_W'(i));

         reg_file_sb_entry #(
            .DATA_W (DATA_W),
            .ZERO   (ZR && (i == 0))
         ) u_ent (
            .clk      (clk),
            .rst      (rst),
            .we       (we_vec[i]),
            .wdata    (rw),
            .pset     (ps_vec[i]),
            .q        (regs[i]),
            .pend     (pend[i]),
            .pend_nxt (pend_nxt[i])
         );
      end
   endgenerate

   // pend_cnt is kept as a register. It is loaded with the population count
   // of the next-state vector, so it tracks pend on the same edge.
   always_comb begin
      cnt_nxt = '0;
      for (int k = 0; k < DEPTH; k++)
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[k]};
   end

   always_ff @(posedge clk) begin
      if (rst) pend_cnt <= '0;
      else     pend_cnt <= cnt_nxt;
   end

   // Read ports. r0 reads as zero even when a write to r0 is being bypassed.
   logic byp1, byp2;
   assign byp1 = BYP & wr & (rd == rs);
   assign byp2 = BYP & wr & (rd == rt);

   always_comb begin
      rout1 = '0;
      rout2 = '0;
      if (!rst) begin
         if (!(ZR && rs == '0)) rout1 = byp1 ? rw : regs[rs];
         if (!(ZR && rt == '0)) rout2 = byp2 ? rw : regs[rt];
      end
   end

   // When bypass is on, an arriving writeback resolves the hazard in the
   // same cycle. pend[0] is never set when r0 is hardwired to zero.
   assign hazard1 = ~rst & pend[rs] & ~byp1;
   assign hazard2 = ~rst & pend[rt] & ~byp2;
endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. Two instances share the same stimulus:
//   ua : ZERO_REG=0, BYPASS=1
//   ub : ZERO_REG=1, BYPASS=0
// Directed sequences are followed by random traffic. Every cycle is
// compared against an array-based reference model of the register file.
module tb_reg_file_sb;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs, rt, rd, pend_addr;
   logic [DW-1:0] rw;
   logic          wr, pend_set;

   logic [DW-1:0] a_r1, a_r2, b_r1, b_r2;
   logic          a_h1, a_h2, b_h1, b_h2;
   logic [AW:0]   a_cnt, b_cnt;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) ua (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .rw(rw), .wr(wr),
      .rout1(a_r1), .rout2(a_r2), .pend_set(pend_set), .pend_addr(pend_addr),
      .hazard1(a_h1), .hazard2(a_h2), .pend_cnt(a_cnt));

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) ub (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .rw(rw), .wr(wr),
      .rout1(b_r1), .rout2(b_r2), .pend_set(pend_set), .pend_addr(pend_addr),
      .hazard1(b_h1), .hazard2(b_h2), .pend_cnt(b_cnt));

   int tests = 0;
   int errs  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model. Index 0 = ua config, index 1 = ub config.
   logic [DW-1:0] mem  [2][N];
   bit            pnd  [2][N];
   bit            zcfg [2] = '{1'b0, 1'b1};
   bit            bcfg [2] = '{1'b1, 1'b0};

   function automatic logic [DW-1:0] m_read(int c, logic [AW-1:0] a);
      if (rst)                         return '0;
      if (zcfg[c] && a == 0)           return '0;
      if (bcfg[c] && wr && rd == a)    return rw;
      return mem[c][a];
   endfunction

   function automatic logic m_haz(int c, logic [AW-1:0] a);
      if (rst) return 1'b0;
      return pnd[c][a] && !(bcfg[c] && wr && rd == a);
   endfunction

   function automatic int m_cnt(int c);
      int n = 0;
      for (int k = 0; k < N; k++) n += pnd[c][k];
      return n;
   endfunction

   task automatic m_update();
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            for (int k = 0; k < N; k++) begin mem[c][k] = '0; pnd[c][k] = 0; end
         end else begin
            if (wr && !(zcfg[c] && rd == 0)) begin
               mem[c][rd] = rw;
               pnd[c][rd] = 0;
            end
            if (pend_set && !(zcfg[c] && pend_addr == 0)) pnd[c][pend_addr] = 1;
         end
      end
   endtask

   // These hold the values sampled in the last step, for the directed checks.
   logic [DW-1:0] sa1, sa2, sb1, sb2;
   logic          sah1, sah2, sbh1, sbh2;
   logic [AW:0]   sac, sbc;
   bit            have_ref = 0;   // model is only valid after the first reset

   // Drive one cycle, check both instances mid-cycle, then apply the edge.
   task automatic step(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ps, input logic [AW-1:0] pa);
      rst = r; rs = a1; rt = a2; wr = w; rd = wa; rw = wd; pend_set = ps; pend_addr = pa;
      @(negedge clk);
      sa1 = a_r1; sa2 = a_r2; sb1 = b_r1; sb2 = b_r2;
      sah1 = a_h1; sah2 = a_h2; sbh1 = b_h1; sbh2 = b_h2;
      sac = a_cnt; sbc = b_cnt;
      if (have_ref) begin
         chk("a_rout1", 32'(a_r1), 32'(m_read(0, rs)));
         chk("a_rout2", 32'(a_r2), 32'(m_read(0, rt)));
         chk("a_haz1",  32'(a_h1), 32'(m_haz(0, rs)));
         chk("a_haz2",  32'(a_h2), 32'(m_haz(0, rt)));
         chk("a_cnt",   32'(a_cnt), 32'(m_cnt(0)));
         chk("b_rout1", 32'(b_r1), 32'(m_read(1, rs)));
         chk("b_rout2", 32'(b_r2), 32'(m_read(1, rt)));
         chk("b_haz1",  32'(b_h1), 32'(m_haz(1, rs)));
         chk("b_haz2",  32'(b_h2), 32'(m_haz(1, rt)));
         chk("b_cnt",   32'(b_cnt), 32'(m_cnt(1)));
      end
      @(posedge clk);
      m_update();
      if (r) have_ref = 1;
      #1;
   endtask

   task automatic rd2(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      step(0, a1, a2, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; rs = 0; rt = 0; rd = 0; rw = 0; wr = 0; pend_set = 0; pend_addr = 0;
      @(posedge clk); #1;

      // 1: reset state and readback
      step(1, 0, 0, 0, 0, 0, 0, 0);
      rd2(3, 15);
      chk("rst_r1", 32'(sa1), 0); chk("rst_cnt", 32'(sac), 0); chk("rst_h1", 32'(sah1), 0);
      step(0, 0, 0, 1, 3, 16'hA5A5, 0, 0);
      step(0, 0, 0, 1, 15, 16'h1234, 0, 0);
      rd2(3, 15);
      chk("t1_a1", 32'(sa1), 32'hA5A5); chk("t1_a2", 32'(sa2), 32'h1234);
      chk("t1_b1", 32'(sb1), 32'hA5A5); chk("t1_b2", 32'(sb2), 32'h1234);
      step(1, 3, 15, 0, 0, 0, 0, 0);
      rd2(3, 15);
      chk("t1_clr1", 32'(sa1), 0); chk("t1_clr2", 32'(sb2), 0); chk("t1_cnt", 32'(sac), 0);

      // 2: bypass versus no bypass
      step(0, 0, 0, 1, 5, 16'h0001, 0, 0);
      step(0, 5, 5, 1, 5, 16'hBEEF, 0, 0);
      chk("t2_byp1", 32'(sa1), 32'hBEEF); chk("t2_byp2", 32'(sa2), 32'hBEEF);
      chk("t2_nob1", 32'(sb1), 32'h0001); chk("t2_nob2", 32'(sb2), 32'h0001);
      rd2(5, 5);
      chk("t2_nob_nx", 32'(sb1), 32'hBEEF);

      // 3: zero register
      step(0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      rd2(0, 0);
      chk("t3_z_r", 32'(sb1), 0); chk("t3_z_h", 32'(sbh1), 0); chk("t3_z_cnt", 32'(sbc), 0);
      chk("t3_nz_r", 32'(sa1), 32'hFFFF); chk("t3_nz_cnt", 32'(sac), 1);

      // 4: RAW hazard resolved by writeback
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 7);
      rd2(7, 0);
      chk("t4_h", 32'(sah1), 1); chk("t4_cnt", 32'(sac), 1); chk("t4_bh", 32'(sbh1), 1);
      step(0, 7, 0, 1, 7, 16'h00C3, 0, 0);
      chk("t4_hbyp", 32'(sah1), 0); chk("t4_rbyp", 32'(sa1), 32'h00C3);
      chk("t4_hnob", 32'(sbh1), 1);
      rd2(7, 0);
      chk("t4_cnt0", 32'(sac), 0); chk("t4_bh0", 32'(sbh1), 0);

      // 5: simultaneous set and clear
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 2);
      step(0, 0, 0, 1, 2, 16'h0022, 1, 2);
      step(0, 0, 0, 1, 2, 16'h0033, 1, 4);
      chk("t5_cnt_same", 32'(sac), 1);
      rd2(4, 2);
      chk("t5_cnt", 32'(sac), 1); chk("t5_h4", 32'(sah1), 1); chk("t5_h2", 32'(sah2), 0);

      // 6: full scoreboard, then reset
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) step(0, 0, 0, 0, 0, 0, 1, AW'(k));
      rd2(9, 0);
      chk("t6_full_a", 32'(sac), 16); chk("t6_full_b", 32'(sbc), 15);
      step(1, 9, 0, 0, 0, 0, 0, 0);
      chk("t6_rst_h", 32'(sah1), 0);
      rd2(9, 1);
      chk("t6_cnt_a", 32'(sac), 0); chk("t6_cnt_b", 32'(sbc), 0);
      chk("t6_h1", 32'(sah1), 0); chk("t6_h2", 32'(sah2), 0);

      // Random traffic. Addresses are drawn from a narrow range so that
      // bypass matches and set/clear collisions are common.
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] lim;
         lim = (n < 300) ? AW'(3) : AW'(15);
         step(($urandom_range(0, 49) == 0),
              AW'($urandom_range(0, int'(lim))), AW'($urandom_range(0, int'(lim))),
              1'($urandom), AW'($urandom_range(0, int'(lim))), DW'($urandom),
              1'($urandom), AW'($urandom_range(0, int'(lim))));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-entry register file for the RISC core datapath. It has two combinational read ports, one clocked write port, optional write-to-read bypass and an optional hardwired-zero register. It adds a per-register pending scoreboard so decode can detect RAW hazards against outstanding multi-cycle writebacks (loads). It sits between decode (rs/rt/rd) and writeback (rw/wr).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 always reads 0, writes and pend_set to it are ignored
BYPASS, 1, 1 = same-cycle write data forwarded to read ports on address match

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
rs  in  ADDR_W  read address, port 1
rt  in  ADDR_W  read address, port 2
rd  in  ADDR_W  write address
rw  in  DATA_W  write data
wr  in  1  write enable
rout1  out  DATA_W  read data, port 1
rout2  out  DATA_W  read data, port 2
pend_set  in  1  mark register pend_addr as pending (outstanding writeback)
pend_addr  in  ADDR_W  register to mark pending
hazard1  out  1  register rs is pending
hazard2  out  1  register rt is pending
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Storage: 2**ADDR_W x DATA_W flops plus a 2**ADDR_W pending bit-vector.
- Reset, on the clk edge with rst=1: every register = 0, every pending bit = 0, pend_cnt = 0.
- While rst=1: rout1, rout2, hazard1 and hazard2 are forced to 0, and wr and pend_set are ignored.
- Write: on a clk edge with wr=1 and rst=0, reg[rd] <= rw.
  - Write latency is 1 cycle. Without bypass, data is visible on the read ports the cycle after the edge.
- Read: combinational, zero latency.
  - rout1 = reg[rs], rout2 = reg[rt].
  - Both ports may address the same register.
- Bypass (BYPASS=1): if wr=1 and rd==rs, rout1 = rw in the same cycle. rout2 behaves the same way for rt.
- Bypass (BYPASS=0): the read returns the old value until after the edge.
- ZERO_REG=1:
  - Reading address 0 returns 0, including under bypass.
  - wr to rd=0 is dropped.
  - pend_set to address 0 is dropped.
  - hazard1 and hazard2 are never asserted for address 0.
- Scoreboard update, each edge with rst=0:
  - pend_set=1 sets pend[pend_addr].
  - wr=1 clears pend[rd].
  - If both events hit the same address in one cycle, set wins: the bit stays 1, because the new load is issued after the old writeback.
  - A wr to a non-pending register is legal and leaves the pend bit 0.
- Hazard flags:
  - hazard1 = pend[rs] & ~(BYPASS & wr & rd==rs). hazard2 uses rt the same way.
  - An arriving writeback therefore resolves the hazard in the same cycle when bypass is enabled.
  - With BYPASS=0 the hazard deasserts the cycle after the write edge.
- pend_cnt:
  - Registered population count of the pend vector, updated on the same edge as the vector.
  - Range 0 .. 2**ADDR_W, which is why the width is ADDR_W+1.
  - A set and a clear to different addresses in one cycle leave the count unchanged.
- Reset mid-operation: pending bits and data are lost. Upstream must discard in-flight loads.
- No X propagation: all outputs are defined for all input values once the first reset has been applied.

Test Plan:
1. Reset/readback: rst=1 for 1 cycle, then write 0xA5A5 to r3 and 0x1234 to r15. Read rs=3, rt=15 -> rout1=0xA5A5, rout2=0x1234. After a second rst pulse -> both read 0, pend_cnt=0.
2. Bypass: BYPASS=1, r5=0x0001; same cycle wr=1, rd=5, rw=0xBEEF, rs=rt=5 -> rout1=rout2=0xBEEF combinationally. Rerun with BYPASS=0 -> 0x0001 that cycle, 0xBEEF the next.
3. Zero register: ZERO_REG=1, write rd=0, rw=0xFFFF, then pend_set with pend_addr=0 -> rout1 at rs=0 reads 0, hazard1=0, pend_cnt=0. With ZERO_REG=0 -> reads 0xFFFF.
4. Scoreboard RAW: pend_set on r7 -> next cycle hazard1=1 at rs=7, pend_cnt=1. Writeback wr=1, rd=7, rw=0x00C3 -> hazard1=0 that cycle (BYPASS=1), rout1=0x00C3, pend_cnt=0 next cycle.
5. Simultaneous set/clear: r2 pending; in one cycle pend_set on r2 plus wr to r2 -> pend[2] stays 1, pend_cnt=1. Next cycle: pend_set on r4 plus wr to r2 -> pend_cnt stays 1, hazard at rs=4 =1, at rs=2 =0.
6. Full scoreboard: pend_set on all 16 addresses over 16 cycles -> pend_cnt=16. Assert rst -> pend_cnt=0 and all hazards 0 on the next cycle.
